ghost_tile_chaser: RTL and testbench

- Parametrised ghost movement controller. Replaces hard-coded waypoint ghosts with tile-map-driven path choice.
- Steps one tile per move tick. At each tile, picks the legal direction that minimises squared distance to a target tile.
- Target alternates between a fixed scatter corner and the player tile, under a step-count mode timer.
- Sits between the tilemap/player logic and the sprite renderer; one instance per ghost.

---
 rtl/ghost_tile_chaser.sv | 268 ++++++++++++++++++++++++++
 tb/tb_ghost_tile_chaser.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ghost_tile_chaser.sv
// Tile-map ghost movement controller: one tile per move tick, greedy shortest-distance steering.
// Optional random "frightened" steering is compiled in with GHOST_FRIGHTENED_EN.

`ifndef WIDTH
`define WIDTH 640
`endif
`ifndef HEIGHT
`define HEIGHT 480
`endif
`ifndef WIDTH_LOG2
`define WIDTH_LOG2 10
`endif
`ifndef DIR_UP
`define DIR_UP 2'd0
`endif
`ifndef DIR_LEFT
`define DIR_LEFT 2'd1
`endif
`ifndef DIR_DOWN
`define DIR_DOWN 2'd2
`endif
`ifndef DIR_RIGHT
`define DIR_RIGHT 2'd3
`endif

module ghost_tile_chaser #(
  parameter int         TILE_SIZE     = 20,
  parameter int         COLS          = 32,
  parameter int         ROWS          = 24,
  parameter int         START_COL     = 1,
  parameter int         START_ROW     = 8,
  parameter logic [1:0] START_DIR     = `DIR_UP,
  parameter int         STEP_PERIOD   = 16,
  parameter int         SCATTER_COL   = 0,
  parameter int         SCATTER_ROW   = 0,
  parameter int         SCATTER_STEPS = 35,
  parameter int         CHASE_STEPS   = 100
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
`ifdef GHOST_FRIGHTENED_EN
  input  logic                        frightened,
`endif
  input  logic [`WIDTH_LOG2-1:0]      player_x,
  input  logic [`WIDTH_LOG2-1:0]      player_y,
  input  logic [ROWS*COLS-1:0]        tilemap_walls,
  output logic [$clog2(`WIDTH)-1:0]   x,
  output logic [$clog2(`HEIGHT)-1:0]  y,
  output logic [1:0]                  ghost_direction,
  output logic                        chase_mode,
  output logic                        step
);

  localparam int XW     = $clog2(`WIDTH);
  localparam int YW     = $clog2(`HEIGHT);
  localparam int CW     = $clog2(COLS);
  localparam int RW     = $clog2(ROWS);
  localparam int WI     = $clog2(ROWS * COLS);
  localparam int TW     = (STEP_PERIOD > 0) ? $clog2(STEP_PERIOD + 1) : 1;
  localparam int MAXS   = (SCATTER_STEPS > CHASE_STEPS) ? SCATTER_STEPS : CHASE_STEPS;
  localparam int MW     = $clog2(MAXS + 1);
  localparam int COST_W = $clog2((COLS - 1) * (COLS - 1) + (ROWS - 1) * (ROWS - 1) + 1);

  localparam logic [1:0] ST_SCATTER = 2'd0;
  localparam logic [1:0] ST_CHASE   = 2'd1;
`ifdef GHOST_FRIGHTENED_EN
  localparam logic [1:0] ST_FRIGHT  = 2'd2;
`endif

  logic [TW-1:0] tick_q, tick_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [1:0]    dir_q, dir_d;
  logic [1:0]    mode_q, mode_d;
  logic [MW-1:0] msteps_q, msteps_d;
  logic          rev_q, rev_d;
`ifdef GHOST_FRIGHTENED_EN
  logic          fr_q, fr_d;
  logic          saved_chase_q, saved_chase_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic          lfsr_fb;
`endif

  logic              tick;
  logic              timer_run;
  int                tgt_c, tgt_r;
  logic [3:0]        open_w;
  logic [3:0]        cand_w;
  logic [COST_W-1:0] cost_w [4];
  logic [1:0]        rev_dir, best_dir, new_dir;
  logic              best_found;
  logic              move_ok;
  logic [MW-1:0]     steps_inc;
  int                steps_lim;

  assign tick = enable && (tick_q == TW'(STEP_PERIOD));

`ifdef GHOST_FRIGHTENED_EN
  assign timer_run = tick && (mode_q != ST_FRIGHT);
`else
  assign timer_run = tick;
`endif

  // Player tile is sampled live so CHASE tracks the player at the moment of the tick.
  assign tgt_c = (mode_q == ST_CHASE) ? int'(player_x) / TILE_SIZE : SCATTER_COL;
  assign tgt_r = (mode_q == ST_CHASE) ? int'(player_y) / TILE_SIZE : SCATTER_ROW;

  // Neighbour d: 0 up, 1 left, 2 down, 3 right. Off-map neighbours count as walls.
  always_comb begin : nbr_c
    int nc, nr;
    for (int d = 0; d < 4; d++) begin
      nc = int'(col_q) + ((d == 3) ? 1 : 0) - ((d == 1) ? 1 : 0);
      nr = int'(row_q) + ((d == 2) ? 1 : 0) - ((d == 0) ? 1 : 0);
      open_w[d] = 1'b0;
      if (nc >= 0 && nc < COLS && nr >= 0 && nr < ROWS)
        open_w[d] = !tilemap_walls[WI'(nr * COLS + nc)];
      cost_w[d] = COST_W'((nc - tgt_c) * (nc - tgt_c) + (nr - tgt_r) * (nr - tgt_r));
    end
  end

  assign rev_dir = dir_q ^ 2'd2;
  assign cand_w  = open_w & ~(4'b0001 << rev_dir);
  assign move_ok = |open_w;

  always_comb begin : pick_c
    best_dir   = 2'd0;
    best_found = 1'b0;
`ifdef GHOST_FRIGHTENED_EN
    if (mode_q == ST_FRIGHT) begin
      // Walk downward so the first open slot in rotation order from LFSR[1:0] wins.
      for (int k = 3; k >= 0; k--) begin
        if (cand_w[lfsr_q[1:0] + 2'(k)]) begin
          best_dir   = lfsr_q[1:0] + 2'(k);
          best_found = 1'b1;
        end
      end
    end else
`endif
    begin
      // Strict less-than keeps the lower index on ties: up > left > down > right.
      for (int d = 0; d < 4; d++) begin
        if (cand_w[d] && (!best_found || cost_w[d] < cost_w[best_dir])) begin
          best_dir   = 2'(d);
          best_found = 1'b1;
        end
      end
    end
  end

  always_comb begin : dir_c
    if (rev_q && open_w[rev_dir]) new_dir = rev_dir;
    else if (best_found)          new_dir = best_dir;
    else                          new_dir = rev_dir;
  end

  assign steps_inc = msteps_q + MW'(1);
  assign steps_lim = (mode_q == ST_CHASE) ? CHASE_STEPS : SCATTER_STEPS;

`ifdef GHOST_FRIGHTENED_EN
  // Right-shift Fibonacci form of x^16+x^14+x^13+x^11+1.
  assign lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
`endif

  always_comb begin : next_c
    tick_d   = tick_q;
    x_d      = x_q;
    y_d      = y_q;
    col_d    = col_q;
    row_d    = row_q;
    dir_d    = dir_q;
    mode_d   = mode_q;
    msteps_d = msteps_q;
    rev_d    = rev_q;
`ifdef GHOST_FRIGHTENED_EN
    fr_d          = frightened;
    saved_chase_d = saved_chase_q;
    lfsr_d        = lfsr_q;
`endif
    if (enable)
      tick_d = (tick_q == TW'(STEP_PERIOD)) ? '0 : tick_q + TW'(1);

    if (tick) begin
      rev_d = 1'b0;
`ifdef GHOST_FRIGHTENED_EN
      lfsr_d = {lfsr_fb, lfsr_q[15:1]};
`endif
      if (move_ok) begin
        dir_d = new_dir;
        case (new_dir)
          `DIR_UP:   begin y_d = y_q - YW'(TILE_SIZE); row_d = row_q - RW'(1); end
          `DIR_LEFT: begin x_d = x_q - XW'(TILE_SIZE); col_d = col_q - CW'(1); end
          `DIR_DOWN: begin y_d = y_q + YW'(TILE_SIZE); row_d = row_q + RW'(1); end
          default:   begin x_d = x_q + XW'(TILE_SIZE); col_d = col_q + CW'(1); end
        endcase
      end
    end

    // Mode flip takes effect for the next tick; this tick already steered on the old target.
    if (timer_run) begin
      if (steps_inc == MW'(steps_lim)) begin
        mode_d   = (mode_q == ST_CHASE) ? ST_SCATTER : ST_CHASE;
        msteps_d = '0;
        rev_d    = 1'b1;
      end else begin
        msteps_d = steps_inc;
      end
    end

`ifdef GHOST_FRIGHTENED_EN
    if (frightened && !fr_q && mode_q != ST_FRIGHT) begin
      saved_chase_d = (mode_q == ST_CHASE);
      mode_d        = ST_FRIGHT;
      msteps_d      = msteps_q;
      rev_d         = 1'b1;
    end else if (!frightened && fr_q && mode_q == ST_FRIGHT) begin
      mode_d = saved_chase_q ? ST_CHASE : ST_SCATTER;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_q   <= '0;
      x_q      <= XW'(START_COL * TILE_SIZE);
      y_q      <= YW'(START_ROW * TILE_SIZE);
      col_q    <= CW'(START_COL);
      row_q    <= RW'(START_ROW);
      dir_q    <= START_DIR;
      mode_q   <= ST_SCATTER;
      msteps_q <= '0;
      rev_q    <= 1'b0;
`ifdef GHOST_FRIGHTENED_EN
      fr_q          <= 1'b0;
      saved_chase_q <= 1'b0;
      lfsr_q        <= 16'hACE1;
`endif
    end else if (enable) begin
      tick_q   <= tick_d;
      x_q      <= x_d;
      y_q      <= y_d;
      col_q    <= col_d;
      row_q    <= row_d;
      dir_q    <= dir_d;
      mode_q   <= mode_d;
      msteps_q <= msteps_d;
      rev_q    <= rev_d;
`ifdef GHOST_FRIGHTENED_EN
      fr_q          <= fr_d;
      saved_chase_q <= saved_chase_d;
      lfsr_q        <= lfsr_d;
`endif
    end
  end

  assign x               = x_q;
  assign y               = y_q;
  assign ghost_direction = dir_q;
  assign step            = tick;
`ifdef GHOST_FRIGHTENED_EN
  assign chase_mode = (mode_q == ST_CHASE) || (mode_q == ST_FRIGHT && saved_chase_q);
`else
  assign chase_mode = (mode_q == ST_CHASE);
`endif

endmodule

// File: tb/tb_ghost_tile_chaser.sv
// Bench for ghost_tile_chaser: directed scenarios plus a randomized run against a tile-level model.
module tb_ghost_tile_chaser;
  localparam int UP = 0, LEFT = 1, DOWN = 2, RIGHT = 3;

  logic         clk = 1'b0, reset = 1'b0, enable = 1'b0;
  logic [9:0]   player_x = '0, player_y = '0;
  logic [767:0] walls = '0;
  logic [9:0]   x1, x2;
  logic [8:0]   y1, y2;
  logic [1:0]   d1, d2;
  logic         cm1, cm2, st1, st2;
  int ncmp = 0, nfail = 0;

  always #5 clk = ~clk;

  ghost_tile_chaser u_dut (
    .clk(clk), .reset(reset), .enable(enable),
`ifdef GHOST_FRIGHTENED_EN
    .frightened(1'b0),
`endif
    .player_x(player_x), .player_y(player_y), .tilemap_walls(walls),
    .x(x1), .y(y1), .ghost_direction(d1), .chase_mode(cm1), .step(st1));

  ghost_tile_chaser #(.SCATTER_STEPS(2), .CHASE_STEPS(5)) u_dut2 (
    .clk(clk), .reset(reset), .enable(enable),
`ifdef GHOST_FRIGHTENED_EN
    .frightened(1'b0),
`endif
    .player_x(player_x), .player_y(player_y), .tilemap_walls(walls),
    .x(x2), .y(y2), .ghost_direction(d2), .chase_mode(cm2), .step(st2));

  // Tile-level model: one entry per instance.
  int m_col[2], m_row[2], m_dir[2], m_mode[2], m_steps[2], m_rev[2], m_cnt[2];
  int m_scat[2]  = '{35, 2};
  int m_chase[2] = '{100, 5};

  task automatic model_init();
    for (int k = 0; k < 2; k++) begin
      m_col[k] = 1; m_row[k] = 8; m_dir[k] = UP; m_mode[k] = 0;
      m_steps[k] = 0; m_rev[k] = 0; m_cnt[k] = 0;
    end
  endtask

  function automatic bit is_open(int c, int r);
    logic [9:0] idx;
    if (c < 0 || c > 31 || r < 0 || r > 23) return 1'b0;
    idx = 10'(r * 32 + c);
    return !walls[idx];
  endfunction

  task automatic model_tick(int k);
    int dc[4] = '{0, -1, 0, 1};
    int dr[4] = '{-1, 0, 1, 0};
    bit opn[4];
    bit any;
    int rev, tc, tr, best, bestc, c, nd, lim;
    any = 0;
    for (int d = 0; d < 4; d++) begin
      opn[d] = is_open(m_col[k] + dc[d], m_row[k] + dr[d]);
      any |= opn[d];
    end
    rev = (m_dir[k] + 2) % 4;
    tc = m_mode[k] ? int'(player_x) / 20 : 0;
    tr = m_mode[k] ? int'(player_y) / 20 : 0;
    if (any) begin
      if (m_rev[k] && opn[rev]) nd = rev;
      else begin
        best = -1; bestc = 0;
        for (int d = 0; d < 4; d++) begin
          if (d != rev && opn[d]) begin
            c = (m_col[k] + dc[d] - tc) ** 2 + (m_row[k] + dr[d] - tr) ** 2;
            if (best < 0 || c < bestc) begin best = d; bestc = c; end
          end
        end
        nd = (best < 0) ? rev : best;
      end
      m_col[k] += dc[nd]; m_row[k] += dr[nd]; m_dir[k] = nd;
    end
    m_rev[k] = 0;
    m_steps[k]++;
    lim = m_mode[k] ? m_chase[k] : m_scat[k];
    if (m_steps[k] == lim) begin
      m_mode[k] = 1 - m_mode[k]; m_steps[k] = 0; m_rev[k] = 1;
    end
  endtask

  task automatic cyc();
    bit en;
    en = enable;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (en) begin
        if (m_cnt[k] == 16) begin model_tick(k); m_cnt[k] = 0; end
        else m_cnt[k]++;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #3;
    model_init();
    reset = 1'b1;
  endtask

  task automatic setw(int c, int r);
    logic [9:0] idx;
    idx = 10'(r * 32 + c);
    walls[idx] = 1'b1;
  endtask

  task automatic test_reset();
    walls = '0; enable = 1'b1;
    do_reset();
    for (int i = 0; i < 20; i++) cyc();
    reset = 1'b0;
    #1;
    ncmp++; if (x1 !== 10'd20) begin nfail++; $display("FAIL reset_x got %0d want 20", x1); end
    ncmp++; if (y1 !== 9'd160) begin nfail++; $display("FAIL reset_y got %0d want 160", y1); end
    ncmp++; if (d1 !== 2'(UP)) begin nfail++; $display("FAIL reset_dir got %0d want %0d", d1, UP); end
    ncmp++; if (cm1 !== 1'b0) begin nfail++; $display("FAIL reset_mode got %0b want 0", cm1); end
    ncmp++; if (st1 !== 1'b0) begin nfail++; $display("FAIL reset_step got %0b want 0", st1); end
    #2;
    model_init();
    reset = 1'b1;
  endtask

  task automatic test_first_step();
    walls = '0; player_x = '0; player_y = '0; enable = 1'b1;
    do_reset();
    for (int i = 0; i < 16; i++) cyc();
    ncmp++; if (st1 !== 1'b1) begin nfail++; $display("FAIL first_step_pulse got %0b want 1", st1); end
    ncmp++; if (y1 !== 9'd160) begin nfail++; $display("FAIL first_step_pre_y got %0d want 160", y1); end
    cyc();
    ncmp++; if (y1 !== 9'd140) begin nfail++; $display("FAIL first_step_y got %0d want 140", y1); end
    ncmp++; if (x1 !== 10'd20) begin nfail++; $display("FAIL first_step_x got %0d want 20", x1); end
    ncmp++; if (d1 !== 2'(UP)) begin nfail++; $display("FAIL first_step_dir got %0d want %0d", d1, UP); end
    ncmp++; if (st1 !== 1'b0) begin nfail++; $display("FAIL first_step_after got %0b want 0", st1); end
  endtask

  task automatic test_enable_hold();
    int n;
    walls = '0; enable = 1'b1;
    do_reset();
    for (int i = 0; i < 5; i++) cyc();
    enable = 1'b0;
    for (int i = 0; i < 50; i++) begin
      cyc();
      ncmp++;
      if (x1 !== 10'd20 || y1 !== 9'd160 || st1 !== 1'b0) begin
        nfail++; $display("FAIL hold_state got x=%0d y=%0d step=%0b want x=20 y=160 step=0", x1, y1, st1);
      end
    end
    enable = 1'b1;
    n = 0;
    while (st1 !== 1'b1 && n < 40) begin cyc(); n++; end
    ncmp++; if (n != 11) begin nfail++; $display("FAIL hold_resume_cycles got %0d want 11", n); end
    cyc();
    ncmp++; if (y1 !== 9'd140) begin nfail++; $display("FAIL hold_resume_y got %0d want 140", y1); end
  endtask

  task automatic test_corridor();
    walls = '0; setw(1, 7); setw(0, 8); enable = 1'b1;
    do_reset();
    for (int i = 0; i < 17; i++) cyc();
    ncmp++; if (d1 !== 2'(RIGHT)) begin nfail++; $display("FAIL corridor_dir got %0d want %0d", d1, RIGHT); end
    ncmp++; if (x1 !== 10'd40 || y1 !== 9'd160) begin nfail++; $display("FAIL corridor_pos got (%0d,%0d) want (40,160)", x1, y1); end
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < 17; i++) cyc();
      ncmp++;
      if (x1 !== 10'(m_col[0] * 20) || y1 !== 9'(m_row[0] * 20) || d1 !== 2'(m_dir[0])) begin
        nfail++; $display("FAIL corridor_follow got (%0d,%0d,%0d) want (%0d,%0d,%0d)",
                          x1, y1, d1, m_col[0] * 20, m_row[0] * 20, m_dir[0]);
      end
    end
  endtask

  task automatic test_dead_end();
    walls = '0;
    setw(1, 7); setw(0, 8); setw(1, 9); setw(2, 7); setw(3, 8); setw(2, 9);
    enable = 1'b1;
    do_reset();
    for (int i = 0; i < 17; i++) cyc();
    ncmp++; if (d1 !== 2'(RIGHT) || x1 !== 10'd40) begin nfail++; $display("FAIL dead_in got dir=%0d x=%0d want dir=3 x=40", d1, x1); end
    for (int i = 0; i < 17; i++) cyc();
    ncmp++; if (d1 !== 2'(LEFT) || x1 !== 10'd20) begin nfail++; $display("FAIL dead_rev got dir=%0d x=%0d want dir=1 x=20", d1, x1); end
    for (int i = 0; i < 17; i++) cyc();
    ncmp++; if (d1 !== 2'(RIGHT) || x1 !== 10'd40) begin nfail++; $display("FAIL dead_back got dir=%0d x=%0d want dir=3 x=40", d1, x1); end
  endtask

  task automatic test_enclosed();
    walls = '0; setw(1, 7); setw(0, 8); setw(1, 9); setw(2, 8); enable = 1'b1;
    do_reset();
    for (int i = 0; i < 16; i++) cyc();
    ncmp++; if (st1 !== 1'b1) begin nfail++; $display("FAIL enclosed_step got %0b want 1", st1); end
    cyc();
    ncmp++; if (x1 !== 10'd20 || y1 !== 9'd160) begin nfail++; $display("FAIL enclosed_pos got (%0d,%0d) want (20,160)", x1, y1); end
    ncmp++; if (d1 !== 2'(UP)) begin nfail++; $display("FAIL enclosed_dir got %0d want %0d", d1, UP); end
  endtask

  task automatic test_mode_switch();
    walls = '0; player_x = 10'd600; player_y = 10'd440; enable = 1'b1;
    do_reset();
    for (int i = 0; i < 17; i++) cyc();
    ncmp++; if (y2 !== 9'd140 || cm2 !== 1'b0) begin nfail++; $display("FAIL mode_t1 got y=%0d mode=%0b want y=140 mode=0", y2, cm2); end
    for (int i = 0; i < 17; i++) cyc();
    ncmp++; if (y2 !== 9'd120) begin nfail++; $display("FAIL mode_t2_y got %0d want 120", y2); end
    ncmp++; if (cm2 !== 1'b1) begin nfail++; $display("FAIL mode_t2_chase got %0b want 1", cm2); end
    for (int i = 0; i < 17; i++) cyc();
    ncmp++; if (d2 !== 2'(DOWN) || y2 !== 9'd140) begin nfail++; $display("FAIL mode_t3_rev got dir=%0d y=%0d want dir=2 y=140", d2, y2); end
    for (int i = 0; i < 17; i++) cyc();
    ncmp++; if (d2 !== 2'(RIGHT) || x2 !== 10'd40 || y2 !== 9'd140) begin
      nfail++; $display("FAIL mode_t4_chase got dir=%0d (%0d,%0d) want dir=3 (40,140)", d2, x2, y2);
    end
    ncmp++; if (cm1 !== 1'b0) begin nfail++; $display("FAIL mode_default_scatter got %0b want 0", cm1); end
  endtask

  task automatic test_random();
    logic [22:0] act, exp;
    logic [9:0]  idx;
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if (i % 500 == 0) begin
        for (int b = 0; b < 768; b++) begin
          idx = 10'(b);
          walls[idx] = ($urandom_range(0, 9) < 2);
        end
        player_x = 10'($urandom_range(0, 639));
        player_y = 10'($urandom_range(0, 479));
      end
      enable = ($urandom_range(0, 7) != 0);
      cyc();
      for (int k = 0; k < 2; k++) begin
        act = (k == 0) ? {x1, y1, d1, cm1, st1} : {x2, y2, d2, cm2, st2};
        exp = {10'(m_col[k] * 20), 9'(m_row[k] * 20), 2'(m_dir[k]), m_mode[k] != 0,
               enable && (m_cnt[k] == 16)};
        ncmp++;
        if (act !== exp) begin
          nfail++; $display("FAIL random_dut%0d cyc %0d got %h want %h", k, i, act, exp);
        end
      end
    end
  endtask

  initial begin
    model_init();
    test_reset();
    test_first_step();
    test_enable_hold();
    test_corridor();
    test_dead_end();
    test_enclosed();
    test_mode_switch();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
